// File: rtl/mem_bus_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory op codes, FSM
// state encoding and small op-classification helpers.
package mem_bus_stage_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need a[0]=0, word ops need a[1:0]=00; byte ops never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic bad;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = a[0];
      MEM_LW, MEM_SW:          bad = (a != 2'b00);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_bus_stage_if.sv
// Single-outstanding req/ack data bus between the MEM stage and memory.
interface mem_bus_stage_if #(parameter int AW = 32) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    sel;
  logic [31:0]   wdata;
  logic          ack;
  logic [31:0]   rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_stage_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated write data for
// stores, lane selection plus sign/zero extension for loads.
module mem_bus_stage_lane_align
  import mem_bus_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword out of the read word (a=00 is data[31:24]).
  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'b00:   byte_lane = rdata[31:24];
      2'b01:   byte_lane = rdata[23:16];
      2'b10:   byte_lane = rdata[15:8];
      2'b11:   byte_lane = rdata[7:0];
      default: byte_lane = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_lane = rdata[15:0];
    end else begin
      half_lane = rdata[31:16];
    end
  end

  // Per-op byte enables, store replication and load extension.
  always_comb begin
    sel       = 4'b0000;
    wdata     = 32'h0000_0000;
    load_data = 32'h0000_0000;
    case (op)
      MEM_LB:  begin sel = 4'b1000 >> addr_lo; load_data = {{24{byte_lane[7]}}, byte_lane}; end
      MEM_LBU: begin sel = 4'b1000 >> addr_lo; load_data = {24'h00_0000, byte_lane}; end
      MEM_LH:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; load_data = {{16{half_lane[15]}}, half_lane}; end
      MEM_LHU: begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; load_data = {16'h0000, half_lane}; end
      MEM_LW:  begin sel = 4'b1111; load_data = rdata; end
      MEM_SB:  begin sel = 4'b1000 >> addr_lo; wdata = {4{store_data[7:0]}}; end
      MEM_SH:  begin sel = addr_lo[1] ? 4'b0011 : 4'b1100; wdata = {2{store_data[15:0]}}; end
      MEM_SW:  begin sel = 4'b1111; wdata = store_data; end
      default: begin sel = 4'b0000; wdata = 32'h0000_0000; load_data = 32'h0000_0000; end
    endcase
  end

endmodule

// File: rtl/mem_bus_stage.sv
// MIPS MEM stage: runs loads/stores over a single-outstanding req/ack bus,
// stalls the pipeline while an access is in flight, passes ALU results through.
module mem_bus_stage
  import mem_bus_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ex_mem_op,
  input  logic [4:0]    ex_w_reg_addr,
  input  logic          ex_we,
  input  logic [DW-1:0] ex_w_data,
  input  logic [AW-1:0] ex_mem_addr,
  input  logic [DW-1:0] ex_store_data,
  input  logic          stall_in,
  input  logic          flush,
  output logic [4:0]    mem_w_reg_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_w_data,
  output logic          stallreq,
  output logic          align_err,
  mem_bus_stage_if.master bus
);

  state_e      state;
  logic [31:0] rdata_q;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;
  logic        op_is_mem;
  logic        op_bad;

  assign op_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);
  assign op_bad    = is_misaligned(ex_mem_op, ex_mem_addr[1:0]);

  mem_bus_stage_lane_align u_lane (
    .op         (ex_mem_op),
    .addr_lo    (ex_mem_addr[1:0]),
    .store_data (ex_store_data),
    .rdata      (bus.rdata),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // FSM plus bus request registers and captured load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.sel   <= 4'b0000;
      bus.wdata <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && op_is_mem && !op_bad) begin
            bus.req   <= 1'b1;
            bus.we    <= is_store(ex_mem_op);
            bus.addr  <= {ex_mem_addr[AW-1:2], 2'b00};
            bus.sel   <= lane_sel;
            bus.wdata <= lane_wdata;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.ack) begin
            bus.req <= 1'b0;
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              rdata_q <= lane_load;
              state   <= ST_DONE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          // Leave once mem_wb has taken the result (or it was killed).
          if (flush || !stall_in) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // A flushed access still has to finish on the bus; its data is dropped.
          if (bus.ack) begin
            bus.req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bus.req <= 1'b0;
        end
      endcase
    end
  end

  // Output mux toward mem_wb and the pipeline controller.
  always_comb begin
    mem_w_reg_addr = 5'd0;
    mem_we         = 1'b0;
    mem_w_data     = '0;
    stallreq       = 1'b0;
    align_err      = 1'b0;
    if (rst) begin
      stallreq = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            stallreq = 1'b0;
          end else if (!op_is_mem) begin
            mem_w_reg_addr = ex_w_reg_addr;
            mem_we         = ex_we;
            mem_w_data     = ex_w_data;
          end else if (op_bad) begin
            align_err = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        ST_WAIT, ST_DRAIN: stallreq = 1'b1;
        ST_DONE: begin
          if (flush) begin
            stallreq = 1'b0;
          end else begin
            mem_w_reg_addr = ex_w_reg_addr;
            mem_we         = ex_we & is_load(ex_mem_op);
            mem_w_data     = rdata_q;
          end
        end
        default: stallreq = 1'b0;
      endcase
    end
  end

endmodule
